// File: rtl/vga_sync_generator.sv
// VGA raster timing: free-running pixel/line counters with registered blanking, sync and
// line/frame-start strobes, all aligned to the o_Col/o_Row values presented in the same cycle.
module vga_sync_generator #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_PixelEn,
  output logic [9:0] o_Col,
  output logic [9:0] o_Row,
  output logic       o_HBlank,
  output logic       o_VBlank,
  output logic       o_Visible,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_HReset,
  output logic       o_VReset
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] h_q;
  logic [9:0] v_q;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       h_wrap;
  logic       v_wrap;
  logic       hblank_nxt;
  logic       vblank_nxt;

  // Every registered output is derived from the next counter values so it lands in the
  // same cycle as the counter it describes.
  always_comb begin
    h_wrap     = (h_q == H_LAST);
    v_wrap     = (v_q == V_LAST);
    h_nxt      = h_wrap ? 10'd0 : h_q + 10'd1;
    v_nxt      = v_q;
    if (h_wrap) begin
      v_nxt = v_wrap ? 10'd0 : v_q + 10'd1;
    end
    hblank_nxt = (h_nxt >= H_VIS);
    vblank_nxt = (v_nxt >= V_VIS);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      h_q       <= 10'd0;
      v_q       <= 10'd0;
      o_HBlank  <= 1'b0;
      o_VBlank  <= 1'b0;
      o_Visible <= 1'b1;
      o_HSync   <= 1'b1;
      o_VSync   <= 1'b1;
      o_HReset  <= 1'b0;
      o_VReset  <= 1'b0;
    end else begin
      // Strobes fire only on the enabled clock that performs the wrap, so they stay one
      // clock wide whatever the enable duty cycle is.
      o_HReset <= i_PixelEn & h_wrap;
      o_VReset <= i_PixelEn & h_wrap & v_wrap;
      if (i_PixelEn) begin
        h_q       <= h_nxt;
        v_q       <= v_nxt;
        o_HBlank  <= hblank_nxt;
        o_VBlank  <= vblank_nxt;
        o_Visible <= ~hblank_nxt & ~vblank_nxt;
        o_HSync   <= ~((h_nxt >= HS_START) && (h_nxt < HS_END));
        o_VSync   <= ~((v_nxt >= VS_START) && (v_nxt < VS_END));
      end
    end
  end

  assign o_Col = h_q;
  assign o_Row = v_q;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Directed bench for vga_sync_generator: default 640x480 timing over a few lines plus a
// small-parameter instance exercised over whole frames.
module tb_vga_sync_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic       d_rst_n, d_en;
  logic [9:0] d_col, d_row;
  logic       d_hblank, d_vblank, d_visible, d_hsync, d_vsync, d_hreset, d_vreset;

  // small-parameter instance (H 8/2/2/2, V 4/1/1/1)
  logic       s_rst_n, s_en;
  logic [9:0] s_col, s_row;
  logic       s_hblank, s_vblank, s_visible, s_hsync, s_vsync, s_hreset, s_vreset;

  vga_sync_generator dut_d (
    .i_Clk(clk), .i_Rst_n(d_rst_n), .i_PixelEn(d_en),
    .o_Col(d_col), .o_Row(d_row), .o_HBlank(d_hblank), .o_VBlank(d_vblank),
    .o_Visible(d_visible), .o_HSync(d_hsync), .o_VSync(d_vsync),
    .o_HReset(d_hreset), .o_VReset(d_vreset)
  );

  vga_sync_generator #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut_s (
    .i_Clk(clk), .i_Rst_n(s_rst_n), .i_PixelEn(s_en),
    .o_Col(s_col), .o_Row(s_row), .o_HBlank(s_hblank), .o_VBlank(s_vblank),
    .o_Visible(s_visible), .o_HSync(s_hsync), .o_VSync(s_vsync),
    .o_HReset(s_hreset), .o_VReset(s_vreset)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else n_pass++;
  endtask

  // {col,row,hblank,vblank,visible,hsync,vsync,hreset,vreset}
  localparam logic [26:0] RST_VEC = {10'd0, 10'd0, 7'b0011100};

  function automatic logic [26:0] d_vec();
    return {d_col, d_row, d_hblank, d_vblank, d_visible, d_hsync, d_vsync, d_hreset, d_vreset};
  endfunction

  function automatic logic [26:0] s_vec();
    return {s_col, s_row, s_hblank, s_vblank, s_visible, s_hsync, s_vsync, s_hreset, s_vreset};
  endfunction

  initial begin
    int first_hr, second_hr, hr_cnt, hs_low, hs_first, hb_first;
    int col_err, vis_err, hs_err, row_at, wide_err, strobe_err;
    int exp_col, exp_row, prev_hr, found;
    logic [26:0] snap;
    int frz_err;

    d_rst_n = 1'b1; s_rst_n = 1'b1; d_en = 1'b0; s_en = 1'b0;
    #1;
    d_rst_n = 1'b0; s_rst_n = 1'b0;
    #1;
    // reset forced before any clock edge
    check("d_reset_async", 32'(d_vec()), 32'(RST_VEC));
    check("s_reset_async", 32'(s_vec()), 32'(RST_VEC));
    repeat (3) @(negedge clk);
    check("d_reset_clocked", 32'(d_vec()), 32'(RST_VEC));

    // ---- default timing, enable held high for just over two lines
    d_rst_n = 1'b1; d_en = 1'b1;
    first_hr = -1; second_hr = -1; hr_cnt = 0; hs_low = 0; hs_first = -1; hb_first = -1;
    col_err = 0; vis_err = 0; hs_err = 0; row_at = -1;
    for (int i = 1; i <= 1700; i++) begin
      @(negedge clk);
      exp_col = i % 800;
      if (int'(d_col) != exp_col) col_err++;
      if (d_hsync !== !(exp_col >= 656 && exp_col < 752)) hs_err++;
      if (d_visible !== (!d_hblank && !d_vblank)) vis_err++;
      if (d_hblank !== (exp_col >= 640)) vis_err++;
      if (d_hreset) begin
        hr_cnt++;
        if (first_hr < 0) first_hr = i;
        else if (second_hr < 0) second_hr = i;
      end
      if (i <= 800) begin
        if (!d_hsync) begin
          hs_low++;
          if (hs_first < 0) hs_first = int'(d_col);
        end
        if (d_hblank && hb_first < 0) hb_first = int'(d_col);
      end
      if (i == 1600) row_at = int'(d_row);
    end
    check("line_col_seq", 32'(col_err), 32'd0);
    check("first_hreset_clk", 32'(first_hr), 32'd800);
    check("hreset_period", 32'(second_hr - first_hr), 32'd800);
    check("hreset_count", 32'(hr_cnt), 32'd2);
    check("hsync_low_len", 32'(hs_low), 32'd96);
    check("hsync_start_col", 32'(hs_first), 32'd656);
    check("hsync_window", 32'(hs_err), 32'd0);
    check("hblank_rise_col", 32'(hb_first), 32'd640);
    check("visible_blank_consistent", 32'(vis_err), 32'd0);
    check("row_after_two_lines", 32'(row_at), 32'd2);
    check("vblank_low_top", 32'(d_vblank), 32'd0);

    // ---- enable 1-of-2: line period doubles, strobe stays one clock wide
    first_hr = -1; second_hr = -1; col_err = 0; wide_err = 0; prev_hr = 0;
    for (int j = 1; j <= 3600; j++) begin
      d_en = (j % 2 == 1);
      @(negedge clk);
      exp_col = (100 + (j + 1) / 2) % 800;
      if (int'(d_col) != exp_col) col_err++;
      if (d_hreset && prev_hr == 1) wide_err++;
      prev_hr = int'(d_hreset);
      if (d_hreset) begin
        if (first_hr < 0) first_hr = j;
        else if (second_hr < 0) second_hr = j;
      end
    end
    check("half_rate_col_seq", 32'(col_err), 32'd0);
    check("half_rate_strobe_width", 32'(wide_err), 32'd0);
    check("half_rate_line_period", 32'(second_hr - first_hr), 32'd1600);
    check("half_rate_row", 32'(d_row), 32'd4);

    // ---- freeze at h=655 for 50 clocks
    d_en = 1'b1;
    found = 0;
    for (int k = 0; k < 1000 && found == 0; k++) begin
      if (d_col == 10'd655) found = 1;
      else @(negedge clk);
    end
    check("reach_col_655", 32'(found), 32'd1);
    d_en = 1'b0;
    snap = d_vec();
    frz_err = 0;
    repeat (50) begin
      @(negedge clk);
      if (d_vec() !== snap) frz_err++;
    end
    check("freeze_stable", 32'(frz_err), 32'd0);
    check("freeze_col", 32'(d_col), 32'd655);
    check("freeze_hsync_high", 32'(d_hsync), 32'd1);
    d_en = 1'b1;
    @(negedge clk);
    check("release_col", 32'(d_col), 32'd656);
    check("release_hsync_low", 32'(d_hsync), 32'd0);

    // ---- reset asserted mid-line at h=700
    found = 0;
    for (int k = 0; k < 1000 && found == 0; k++) begin
      if (d_col == 10'd700) found = 1;
      else @(negedge clk);
    end
    check("reach_col_700", 32'(found), 32'd1);
    #2;
    d_rst_n = 1'b0;
    #1;
    check("midline_reset_async", 32'(d_vec()), 32'(RST_VEC));
    @(negedge clk);
    d_rst_n = 1'b1;
    col_err = 0; strobe_err = 0;
    for (int i = 1; i <= 810; i++) begin
      @(negedge clk);
      if (i == 1) check("post_reset_col1", 32'(d_col), 32'd1);
      if (i == 2) check("post_reset_col2", 32'(d_col), 32'd2);
      if (int'(d_col) != i % 800) col_err++;
      if (d_hreset !== (i == 800)) strobe_err++;
      if (d_vreset !== 1'b0) strobe_err++;
    end
    check("post_reset_col_seq", 32'(col_err), 32'd0);
    check("post_reset_strobes", 32'(strobe_err), 32'd0);

    // ---- small parameters over three full frames (H_TOTAL 14, V_TOTAL 7)
    @(negedge clk);
    s_rst_n = 1'b1; s_en = 1'b1;
    begin
      int cnt_err, sync_err, blank_err, hr_err, vr_err, vis_cnt, vr_cnt, hr_tot;
      int h, v;
      cnt_err = 0; sync_err = 0; blank_err = 0; hr_err = 0; vr_err = 0;
      vis_cnt = 0; vr_cnt = 0; hr_tot = 0;
      for (int i = 1; i <= 294; i++) begin
        @(negedge clk);
        h = i % 14;
        v = (i / 14) % 7;
        if (int'(s_col) != h || int'(s_row) != v) cnt_err++;
        if (s_hsync !== !(h >= 10 && h <= 11)) sync_err++;
        if (s_vsync !== !(v == 5)) sync_err++;
        if (s_hblank !== (h >= 8) || s_vblank !== (v >= 4)) blank_err++;
        if (s_visible !== (h < 8 && v < 4)) blank_err++;
        if (s_hreset !== (h == 0)) hr_err++;
        if (s_vreset !== (h == 0 && v == 0)) vr_err++;
        if (i <= 98 && s_visible) vis_cnt++;
        if (s_vreset) vr_cnt++;
        if (s_hreset) hr_tot++;
      end
      check("small_counters", 32'(cnt_err), 32'd0);
      check("small_sync_windows", 32'(sync_err), 32'd0);
      check("small_blanking", 32'(blank_err), 32'd0);
      check("small_hreset", 32'(hr_err), 32'd0);
      check("small_vreset", 32'(vr_err), 32'd0);
      check("small_visible_per_frame", 32'(vis_cnt), 32'd32);
      check("small_vreset_count", 32'(vr_cnt), 32'd3);
      check("small_hreset_count", 32'(hr_tot), 32'd21);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
